// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: captures branches from ID, resolves them with the external
// comparator result, then issues a one-cycle PC redirect followed by a counted IF/ID flush.
module branch_resolve_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             id_valid,
    input  logic             id_branch,
    input  logic [2:0]       id_op,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      id_offset,
    output logic [2:0]       cmp_op,
    input  logic             cmp_out,
    output logic             redirect,
    output logic [31:0]      br_target,
    output logic             flush,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RESOLVE,
        FLUSH
    } state_t;

    logic             r_exValid;
    logic [2:0]       r_exOp;
    logic [31:0]      r_exPc;
    logic [31:0]      r_exOff;
    logic             r_redirect;
    logic [31:0]      r_brTarget;
    logic [2:0]       r_flushCnt;
    logic [CNT_W-1:0] r_branchCnt;
    logic [CNT_W-1:0] r_takenCnt;

    state_t           w_state;
    logic             w_resolve;
    logic             w_taken;
    logic             w_nExValid;
    logic [2:0]       w_nExOp;
    logic [31:0]      w_nExPc;
    logic [31:0]      w_nExOff;
    logic [31:0]      w_nBrTarget;
    logic [2:0]       w_nFlushCnt;
    logic [CNT_W-1:0] w_nBranchCnt;
    logic [CNT_W-1:0] w_nTakenCnt;

    // The redirect cycle always overlaps a nonzero flush count, so FLUSH covers both.
    always_comb begin
        if (r_redirect || (r_flushCnt != 3'd0)) begin
            w_state = FLUSH;
        end else if (r_exValid) begin
            w_state = RESOLVE;
        end else begin
            w_state = IDLE;
        end
    end

    always_comb begin
        w_nExValid   = r_exValid;
        w_nExOp      = r_exOp;
        w_nExPc      = r_exPc;
        w_nExOff     = r_exOff;
        w_nBrTarget  = r_brTarget;
        w_nBranchCnt = r_branchCnt;
        w_nTakenCnt  = r_takenCnt;
        w_nFlushCnt  = (r_flushCnt != 3'd0) ? r_flushCnt - 3'd1 : 3'd0;

        w_resolve = (w_state == RESOLVE) && !stall;
        w_taken   = w_resolve && cmp_out && (r_exOp <= 3'b101);

        if (w_resolve && (r_branchCnt != {CNT_W{1'b1}})) begin
            w_nBranchCnt = r_branchCnt + 1'b1;
        end
        if (w_taken) begin
            if (r_takenCnt != {CNT_W{1'b1}}) begin
                w_nTakenCnt = r_takenCnt + 1'b1;
            end
            w_nBrTarget = r_exPc + 32'd4 + {r_exOff[29:0], 2'b00};
            w_nFlushCnt = 3'(FLUSH_CYCLES);
        end

        // A younger branch sitting in EX during redirect/flush is killed even if stalled.
        if (w_state == FLUSH) begin
            w_nExValid = 1'b0;
        end else if (!stall) begin
            w_nExValid = id_valid && id_branch;
            if (id_valid && id_branch) begin
                w_nExOp  = id_op;
                w_nExPc  = id_pc;
                w_nExOff = id_offset;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_exValid   <= 1'b0;
            r_exOp      <= 3'b000;
            r_exPc      <= 32'd0;
            r_exOff     <= 32'd0;
            r_redirect  <= 1'b0;
            r_brTarget  <= 32'd0;
            r_flushCnt  <= 3'd0;
            r_branchCnt <= '0;
            r_takenCnt  <= '0;
        end else begin
            r_exValid   <= w_nExValid;
            r_exOp      <= w_nExOp;
            r_exPc      <= w_nExPc;
            r_exOff     <= w_nExOff;
            r_redirect  <= w_taken;
            r_brTarget  <= w_nBrTarget;
            r_flushCnt  <= w_nFlushCnt;
            r_branchCnt <= w_nBranchCnt;
            r_takenCnt  <= w_nTakenCnt;
        end
    end

    assign cmp_op     = r_exOp;
    assign redirect   = r_redirect;
    assign br_target  = r_brTarget;
    assign flush      = (r_flushCnt != 3'd0);
    assign branch_cnt = r_branchCnt;
    assign taken_cnt  = r_takenCnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a transaction-level model predicts every cycle's
// outputs and each redirect target; an independent monitor pops and compares.
module tb_branch_resolve_unit;

    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 4;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic             clock;
    logic             reset;
    logic             stall;
    logic             id_valid;
    logic             id_branch;
    logic [2:0]       id_op;
    logic [31:0]      id_pc;
    logic [31:0]      id_offset;
    logic [2:0]       cmp_op;
    logic             cmp_out;
    logic             redirect;
    logic [31:0]      br_target;
    logic             flush;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    branch_resolve_unit #(
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .stall     (stall),
        .id_valid  (id_valid),
        .id_branch (id_branch),
        .id_op     (id_op),
        .id_pc     (id_pc),
        .id_offset (id_offset),
        .cmp_op    (cmp_op),
        .cmp_out   (cmp_out),
        .redirect  (redirect),
        .br_target (br_target),
        .flush     (flush),
        .branch_cnt(branch_cnt),
        .taken_cnt (taken_cnt)
    );

    typedef struct {
        logic        redirect;
        logic [31:0] target;
        logic        flush;
        logic [2:0]  op;
        int          br;
        int          tk;
    } status_t;

    status_t     statusQ[$];
    logic [31:0] redirectQ[$];

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model: the branch waiting in EX, the pending redirect and the flush time left.
    bit          mValid    = 0;
    logic [2:0]  mOp       = 3'b000;
    logic [31:0] mPc       = 32'd0;
    logic [31:0] mOff      = 32'd0;
    bit          mRedirect = 0;
    logic [31:0] mTarget   = 32'd0;
    int          mFlush    = 0;
    int          mBr       = 0;
    int          mTk       = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advances the model across one clock edge with the inputs that will be sampled there.
    task automatic modelEdge(input bit rstN, input bit st, input bit iv, input bit ib,
                             input logic [2:0] op, input logic [31:0] pc, input logic [31:0] off,
                             input bit cmp);
        bit      busy;
        bit      resolved;
        bit      taken;
        longint  sum;
        status_t s;
        if (!rstN) begin
            mValid = 0; mOp = 3'b000; mPc = 0; mOff = 0;
            mRedirect = 0; mTarget = 0; mFlush = 0; mBr = 0; mTk = 0;
        end else begin
            busy     = mRedirect || (mFlush > 0);
            resolved = mValid && !st && !busy;
            taken    = resolved && cmp && (mOp <= 3'd5);
            mFlush   = taken ? FLUSH_CYCLES : ((mFlush > 0) ? mFlush - 1 : 0);
            mRedirect = taken;
            if (resolved) mBr = (mBr < CNT_MAX) ? mBr + 1 : CNT_MAX;
            if (taken) begin
                mTk = (mTk < CNT_MAX) ? mTk + 1 : CNT_MAX;
                sum = longint'(mPc) + 4 + longint'(mOff) * 4;
                mTarget = 32'(sum % 64'h1_0000_0000);
                redirectQ.push_back(mTarget);
            end
            if (busy) begin
                mValid = 0;
            end else if (!st) begin
                mValid = iv && ib;
                if (iv && ib) begin
                    mOp = op; mPc = pc; mOff = off;
                end
            end
        end
        s.redirect = mRedirect;
        s.target   = mTarget;
        s.flush    = (mFlush > 0);
        s.op       = mOp;
        s.br       = mBr;
        s.tk       = mTk;
        statusQ.push_back(s);
    endtask

    task automatic applyStimulus(input bit rstN, input bit st, input bit iv, input bit ib,
                                 input logic [2:0] op, input logic [31:0] pc,
                                 input logic [31:0] off, input bit cmp);
        @(negedge clock);
        reset     = rstN;
        stall     = st;
        id_valid  = iv;
        id_branch = ib;
        id_op     = op;
        id_pc     = pc;
        id_offset = off;
        cmp_out   = cmp;
        modelEdge(rstN, st, iv, ib, op, pc, off, cmp);
    endtask

    task automatic idle(input int n, input bit cmp);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 3'b000, 32'd0, 32'd0, cmp);
    endtask

    // Monitor: every cycle's outputs against the oldest prediction, redirects against targets.
    initial begin
        status_t     s;
        logic [31:0] t;
        forever begin
            @(posedge clock);
            #1;
            if (statusQ.size() > 0) begin
                s = statusQ.pop_front();
                checkOutput("redirect", 32'(redirect), 32'(s.redirect));
                checkOutput("br_target", br_target, s.target);
                checkOutput("flush", 32'(flush), 32'(s.flush));
                checkOutput("cmp_op", 32'(cmp_op), 32'(s.op));
                checkOutput("branch_cnt", 32'(branch_cnt), 32'(s.br));
                checkOutput("taken_cnt", 32'(taken_cnt), 32'(s.tk));
                if (redirect === 1'b1) begin
                    if (redirectQ.size() == 0) begin
                        nCompared++;
                        nMismatched++;
                        $display("[TB] FAIL unexpectedRedirect: got target %h, expected no redirect at %0t",
                                 br_target, $time);
                    end else begin
                        t = redirectQ.pop_front();
                        checkOutput("redirectTarget", br_target, t);
                    end
                end else if (s.redirect && redirectQ.size() > 0) begin
                    t = redirectQ.pop_front();
                end
            end
        end
    end

    initial begin
        reset = 1'b0; stall = 1'b0; id_valid = 1'b0; id_branch = 1'b0;
        id_op = 3'b000; id_pc = 32'd0; id_offset = 32'd0; cmp_out = 1'b0;

        // Reset held with random activity on every input.
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
                          $urandom, $urandom, 1'($urandom));

        // Single taken branch.
        applyStimulus(1, 0, 1, 1, 3'b000, 32'h0000_0100, 32'h0000_0004, 0);
        applyStimulus(1, 0, 0, 0, 3'b000, 32'd0, 32'd0, 1);
        idle(3, 0);

        // Single not-taken branch.
        applyStimulus(1, 0, 1, 1, 3'b000, 32'h0000_0100, 32'h0000_0004, 0);
        applyStimulus(1, 0, 0, 0, 3'b000, 32'd0, 32'd0, 0);
        idle(2, 0);

        // Back-to-back taken branches: the second one is squashed.
        applyStimulus(1, 0, 1, 1, 3'b001, 32'h0000_2000, 32'hFFFF_FFF0, 1);
        applyStimulus(1, 0, 1, 1, 3'b010, 32'h0000_3000, 32'h0000_0010, 1);
        idle(4, 1);

        // Stall across the resolve cycle.
        applyStimulus(1, 0, 1, 1, 3'b011, 32'h0000_4000, 32'h0000_0008, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 3'b000, 32'd0, 32'd0, 1);
        applyStimulus(1, 0, 0, 0, 3'b000, 32'd0, 32'd0, 1);
        idle(3, 0);

        // Reserved op never taken, target wraparound, then reset during the flush.
        applyStimulus(1, 0, 1, 1, 3'b110, 32'h0000_5000, 32'h0000_0004, 0);
        applyStimulus(1, 0, 0, 0, 3'b000, 32'd0, 32'd0, 1);
        idle(1, 0);
        applyStimulus(1, 0, 1, 1, 3'b101, 32'hFFFF_FFFC, 32'h0000_0000, 0);
        applyStimulus(1, 0, 0, 0, 3'b000, 32'd0, 32'd0, 1);
        applyStimulus(1, 0, 0, 0, 3'b000, 32'd0, 32'd0, 0);
        applyStimulus(0, 0, 0, 0, 3'b000, 32'd0, 32'd0, 0);
        idle(2, 0);

        // Stream of not-taken branches drives branch_cnt into saturation.
        for (int i = 0; i < 20; i++)
            applyStimulus(1, 0, 1, 1, 3'($urandom_range(5)), $urandom, $urandom, 0);
        idle(2, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(99) >= 1,
                          $urandom_range(99) < 20,
                          $urandom_range(99) < 75,
                          $urandom_range(99) < 85,
                          3'($urandom_range(7)),
                          $urandom,
                          ($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(63)) - 32'd32,
                          1'($urandom));
        end
        idle(3, 0);

        repeat (2) @(posedge clock);
        #2;
        checkOutput("statusQueueDrained", 32'(statusQ.size()), 32'd0);
        checkOutput("redirectQueueDrained", 32'(redirectQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
